rotation_aligner: RTL and testbench



---
 rtl/rotation_aligner_pkg.sv | 16 +
 rtl/rotation_aligner_if.sv | 27 ++
 rtl/rotation_aligner_barrel_shifter.sv | 33 +++
 rtl/rotation_aligner.sv | 184 ++++++++++++++++++
 tb/tb_rotation_aligner.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/rotation_aligner_pkg.sv
// rotation_aligner_pkg: shared types and constants for the rotation aligner.
//   state_t            - aligner states (SEARCH=0, CONFIRM=1, LOCKED=2)
//   DEFAULT_SYNC_WORD  - unrotated sync word used when no override is given
//   COUNT_WIDTH        - width of the good-sync / missed-sync counters
package rotation_aligner_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hB8;
    localparam int         COUNT_WIDTH       = 8;

endpackage

// File: rtl/rotation_aligner_if.sv
// rotation_aligner_if: word stream in, de-rotated stream and lock status out.
//   in_valid/in_data            - rotated input words
//   out_valid/out_data/out_sof  - de-rotated words, out_sof marks the sync word
//   locked/shift_amount         - alignment status and current rotation
// Modports: master drives the input stream, slave is the aligner.
interface rotation_aligner_if #(
    parameter int WIDTH       = 8,
    parameter int SHIFT_WIDTH = 3
);
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_sof;
    logic                   locked;
    logic [SHIFT_WIDTH-1:0] shift_amount;

    modport master (
        output in_valid, in_data,
        input  out_valid, out_data, out_sof, locked, shift_amount
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, out_data, out_sof, locked, shift_amount
    );
endinterface

// File: rtl/rotation_aligner_barrel_shifter.sv
// barrel_shifter: combinational rotator.
//   data_in      - word to rotate
//   shift_amount - rotation distance (0..WIDTH-1)
//   direction    - 0 rotates right, 1 rotates left
//   data_out     - rotated word
module barrel_shifter #(
    parameter int WIDTH       = 8,
    parameter int SHIFT_WIDTH = 3
) (
    input  logic [WIDTH-1:0]       data_in,
    input  logic [SHIFT_WIDTH-1:0] shift_amount,
    input  logic                   direction,
    output logic [WIDTH-1:0]       data_out
);
    // Doubled word minus its top bit: any WIDTH-bit window starting at k
    // is the input rotated right by k.
    logic [2*WIDTH-2:0]     dbl_s;
    logic [SHIFT_WIDTH-1:0] idx_s;

    assign dbl_s = {data_in[WIDTH-2:0], data_in};

    // Select window start; a left rotation by k is a right rotation by WIDTH-k.
    always_comb begin
        idx_s = shift_amount;
        if (direction == 1'b0) begin
            idx_s = shift_amount;
        end else begin
            idx_s = SHIFT_WIDTH'(0) - shift_amount;
        end
    end

    assign data_out = dbl_s[idx_s +: WIDTH];
endmodule

// File: rtl/rotation_aligner.sv
// rotation_aligner: finds the unknown rotation of a framed word stream from
// its sync word, locks after LOCK_COUNT consecutive good syncs, drops lock
// after MISS_LIMIT consecutive missed syncs, and outputs de-rotated words
// one cycle after input while locked.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - rotation_aligner_if slave (stream in, stream/status out)
module rotation_aligner
    import rotation_aligner_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SHIFT_WIDTH = 3,
    parameter logic [WIDTH-1:0] SYNC_WORD   = DEFAULT_SYNC_WORD,
    parameter int               FRAME_LEN   = 8,
    parameter int               LOCK_COUNT  = 2,
    parameter int               MISS_LIMIT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    rotation_aligner_if.slave bus
);
    localparam int POS_WIDTH = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [POS_WIDTH-1:0] POS_LAST  = POS_WIDTH'(FRAME_LEN - 1);
    localparam logic [POS_WIDTH-1:0] POS_AFTER = POS_WIDTH'((FRAME_LEN > 1) ? 1 : 0);

    state_t                 state_r, state_nxt_s;
    logic [POS_WIDTH-1:0]   pos_r, pos_nxt_s, pos_inc_s;
    logic [COUNT_WIDTH-1:0] good_r, good_nxt_s, good_inc_s;
    logic [COUNT_WIDTH-1:0] miss_r, miss_nxt_s, miss_inc_s;
    logic [SHIFT_WIDTH-1:0] shift_r, shift_nxt_s;
    logic                   out_valid_r, out_sof_r, locked_r;
    logic [WIDTH-1:0]       out_data_r;

    logic [2*WIDTH-2:0]     dbl_s;
    logic [WIDTH-1:0]       match_s;
    logic                   hit_s;
    logic [SHIFT_WIDTH-1:0] hit_k_s;
    logic [WIDTH-1:0]       derot_s;
    logic                   sync_ok_s;
    logic                   emit_s, sof_s;
    logic [WIDTH-1:0]       emit_data_s;

    // All-rotation sync compare used while searching.
    assign dbl_s = {bus.in_data[WIDTH-2:0], bus.in_data};
    for (genvar k = 0; k < WIDTH; k++) begin : g_match
        assign match_s[k] = (dbl_s[k +: WIDTH] == SYNC_WORD);
    end

    // Lowest matching rotation wins: scan downwards so lower k overrides.
    always_comb begin
        hit_s   = 1'b0;
        hit_k_s = SHIFT_WIDTH'(0);
        for (int k = WIDTH - 1; k >= 0; k--) begin
            hit_s   = match_s[k] ? 1'b1 : hit_s;
            hit_k_s = match_s[k] ? SHIFT_WIDTH'(k) : hit_k_s;
        end
    end

    barrel_shifter #(
        .WIDTH       (WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_derot (
        .data_in      (bus.in_data),
        .shift_amount (shift_r),
        .direction    (1'b0),
        .data_out     (derot_s)
    );

    assign sync_ok_s  = (derot_s == SYNC_WORD);
    assign pos_inc_s  = (pos_r == POS_LAST) ? POS_WIDTH'(0) : pos_r + POS_WIDTH'(1);
    assign good_inc_s = good_r + COUNT_WIDTH'(1);
    assign miss_inc_s = miss_r + COUNT_WIDTH'(1);

    // Next-state, counter and output-enable decode.
    always_comb begin
        state_nxt_s = state_r;
        pos_nxt_s   = pos_r;
        good_nxt_s  = good_r;
        miss_nxt_s  = miss_r;
        shift_nxt_s = shift_r;
        emit_s      = 1'b0;
        sof_s       = 1'b0;
        emit_data_s = derot_s;
        if (bus.in_valid) begin
            pos_nxt_s = pos_inc_s;
            case (state_r)
                SEARCH: begin
                    if (hit_s) begin
                        shift_nxt_s = hit_k_s;
                        pos_nxt_s   = POS_AFTER;
                        good_nxt_s  = COUNT_WIDTH'(1);
                        if (LOCK_COUNT == 1) begin
                            // Derotation uses the old k this cycle; a match
                            // means the de-rotated word is the sync word.
                            state_nxt_s = LOCKED;
                            miss_nxt_s  = COUNT_WIDTH'(0);
                            emit_s      = 1'b1;
                            sof_s       = 1'b1;
                            emit_data_s = SYNC_WORD;
                        end else begin
                            state_nxt_s = CONFIRM;
                        end
                    end else begin
                        pos_nxt_s = POS_WIDTH'(0);
                    end
                end
                CONFIRM: begin
                    if (pos_r != POS_WIDTH'(0)) begin
                        state_nxt_s = CONFIRM;
                    end else if (sync_ok_s) begin
                        good_nxt_s = good_inc_s;
                        if (good_inc_s >= COUNT_WIDTH'(LOCK_COUNT)) begin
                            state_nxt_s = LOCKED;
                            miss_nxt_s  = COUNT_WIDTH'(0);
                            emit_s      = 1'b1;
                            sof_s       = 1'b1;
                        end else begin
                            state_nxt_s = CONFIRM;
                        end
                    end else begin
                        state_nxt_s = SEARCH;
                        pos_nxt_s   = POS_WIDTH'(0);
                        good_nxt_s  = COUNT_WIDTH'(0);
                    end
                end
                LOCKED: begin
                    emit_s = 1'b1;
                    if (pos_r != POS_WIDTH'(0)) begin
                        sof_s = 1'b0;
                    end else if (sync_ok_s) begin
                        miss_nxt_s = COUNT_WIDTH'(0);
                        sof_s      = 1'b1;
                    end else if (miss_inc_s >= COUNT_WIDTH'(MISS_LIMIT)) begin
                        state_nxt_s = SEARCH;
                        pos_nxt_s   = POS_WIDTH'(0);
                        good_nxt_s  = COUNT_WIDTH'(0);
                        miss_nxt_s  = COUNT_WIDTH'(0);
                        emit_s      = 1'b0;
                    end else begin
                        miss_nxt_s = miss_inc_s;
                    end
                end
                default: begin
                    state_nxt_s = SEARCH;
                    pos_nxt_s   = POS_WIDTH'(0);
                    good_nxt_s  = COUNT_WIDTH'(0);
                    miss_nxt_s  = COUNT_WIDTH'(0);
                end
            endcase
        end else begin
            pos_nxt_s = pos_r;
        end
    end

    // State, counters, rotation and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= SEARCH;
            pos_r       <= POS_WIDTH'(0);
            good_r      <= COUNT_WIDTH'(0);
            miss_r      <= COUNT_WIDTH'(0);
            shift_r     <= SHIFT_WIDTH'(0);
            out_valid_r <= 1'b0;
            out_sof_r   <= 1'b0;
            out_data_r  <= WIDTH'(0);
            locked_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pos_r       <= pos_nxt_s;
            good_r      <= good_nxt_s;
            miss_r      <= miss_nxt_s;
            shift_r     <= shift_nxt_s;
            out_valid_r <= emit_s;
            out_sof_r   <= sof_s;
            out_data_r  <= emit_s ? emit_data_s : out_data_r;
            locked_r    <= (state_nxt_s == LOCKED);
        end
    end

    assign bus.out_valid    = out_valid_r;
    assign bus.out_data     = out_data_r;
    assign bus.out_sof      = out_sof_r;
    assign bus.locked       = locked_r;
    assign bus.shift_amount = shift_r;
endmodule

// File: tb/tb_rotation_aligner.sv
// tb_rotation_aligner: drives directed and random framed streams into the
// aligner and compares every cycle with a frame-level reference model.
module tb_rotation_aligner;
    localparam int         FL   = 8;
    localparam int         LC   = 2;
    localparam int         ML   = 2;
    localparam logic [7:0] SYNC = 8'hB8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    rotation_aligner_if #(.WIDTH(8), .SHIFT_WIDTH(3)) bus ();

    rotation_aligner #(
        .WIDTH(8), .SHIFT_WIDTH(3), .SYNC_WORD(SYNC),
        .FRAME_LEN(FL), .LOCK_COUNT(LC), .MISS_LIMIT(ML)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 hunting, 1 confirming, 2 aligned.
    int         m_mode, m_pos, m_good, m_miss, m_k;
    logic       e_valid, e_sof;
    logic [7:0] e_data;

    function automatic logic [7:0] rotr(input logic [7:0] x, input int k);
        int kk;
        kk = k % 8;
        if (kk == 0) return x;
        return (x >> kk) | (x << (8 - kk));
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
        return rotr(x, (8 - (k % 8)) % 8);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0; m_k = 0;
        e_valid = 1'b0; e_sof = 1'b0; e_data = 8'h00;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        int found;
        e_valid = 1'b0;
        e_sof   = 1'b0;
        if (!v) return;
        if (m_mode == 0) begin
            found = -1;
            for (int k = 7; k >= 0; k--) if (rotr(d, k) == SYNC) found = k;
            if (found >= 0) begin
                m_k = found; m_pos = 1 % FL; m_good = 1;
                if (LC == 1) begin
                    m_mode = 2; m_miss = 0;
                    e_valid = 1'b1; e_sof = 1'b1; e_data = SYNC;
                end else begin
                    m_mode = 1;
                end
            end
        end else if (m_mode == 1) begin
            if (m_pos != 0) begin
                m_pos = (m_pos + 1) % FL;
            end else if (rotr(d, m_k) == SYNC) begin
                m_good++;
                m_pos = 1 % FL;
                if (m_good >= LC) begin
                    m_mode = 2; m_miss = 0;
                    e_valid = 1'b1; e_sof = 1'b1; e_data = SYNC;
                end
            end else begin
                m_mode = 0; m_pos = 0; m_good = 0;
            end
        end else begin
            if (m_pos == 0 && rotr(d, m_k) != SYNC && m_miss + 1 >= ML) begin
                m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0;
            end else begin
                if (m_pos == 0) begin
                    if (rotr(d, m_k) == SYNC) begin
                        m_miss = 0; e_sof = 1'b1;
                    end else begin
                        m_miss++;
                    end
                end
                e_valid = 1'b1;
                e_data  = rotr(d, m_k);
                m_pos   = (m_pos + 1) % FL;
            end
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("out_valid", 32'(bus.out_valid), 32'(e_valid));
        check_eq("out_sof", 32'(bus.out_sof), 32'(e_sof));
        check_eq("out_data", 32'(bus.out_data), 32'(e_data));
        check_eq("locked", 32'(bus.locked), 32'(m_mode == 2));
        check_eq("shift_amount", 32'(bus.shift_amount), 32'(m_k));
    endtask

    // One input cycle: drive away from the edge, clock, then compare.
    task automatic step(input logic v, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        model_step(v, d);
        check_outputs();
    endtask

    task automatic send_frame(input logic [7:0] s, input logic [7:0] d);
        step(1'b1, s);
        for (int i = 1; i < FL; i++) step(1'b1, d);
    endtask

    task automatic check_reset_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_data"}, 32'(bus.out_data), 32'd0);
        check_eq({tag, "_sof"}, 32'(bus.out_sof), 32'd0);
        check_eq({tag, "_locked"}, 32'(bus.locked), 32'd0);
        check_eq({tag, "_shift"}, 32'(bus.shift_amount), 32'd0);
    endtask

    initial begin
        logic [7:0] s;
        logic [7:0] d;
        int         k;
        n_checks = 0;
        n_fail   = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_zero("rst_init");
        rst_n = 1'b1;

        // Acquire k=3 with C5 syncs and 90 data.
        send_frame(8'hC5, 8'h90);
        check_eq("k3_shift_after_first", 32'(bus.shift_amount), 32'd3);
        check_eq("k3_not_locked_yet", 32'(bus.locked), 32'd0);
        step(1'b1, 8'hC5);
        check_eq("k3_locked", 32'(bus.locked), 32'd1);
        check_eq("k3_sync_out", 32'(bus.out_data), 32'hB8);
        check_eq("k3_sof", 32'(bus.out_sof), 32'd1);
        step(1'b1, 8'h90);
        check_eq("k3_data_out", 32'(bus.out_data), 32'h12);
        for (int i = 2; i < FL; i++) step(1'b1, 8'h90);
        send_frame(8'hC5, 8'h90);

        // One bad sync holds lock; two in a row drop it.
        send_frame(8'h00, 8'h90);
        send_frame(8'hC5, 8'h90);
        check_eq("loss_one_held", 32'(bus.locked), 32'd1);
        send_frame(8'h00, 8'h90);
        step(1'b1, 8'h00);
        check_eq("loss_two_unlocked", 32'(bus.locked), 32'd0);
        check_eq("loss_two_novalid", 32'(bus.out_valid), 32'd0);
        for (int i = 1; i < FL; i++) step(1'b1, 8'h90);

        // Reacquire, then gaps inside frames.
        send_frame(8'hC5, 8'h90);
        send_frame(8'hC5, 8'h90);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < FL; i++) begin
                if (i == 3 || i == 0) begin
                    step(1'b0, 8'hC5);
                    check_eq("gap_novalid", 32'(bus.out_valid), 32'd0);
                end
                step(1'b1, (i == 0) ? 8'hC5 : 8'h90);
            end
        end
        check_eq("gap_lock_kept", 32'(bus.locked), 32'd1);

        // Asynchronous reset mid-lock, off the clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_zero("rst_mid");
        @(posedge clk);
        #1;
        check_reset_zero("rst_hold");
        rst_n = 1'b1;

        // Identity rotation.
        send_frame(8'hB8, 8'h34);
        send_frame(8'hB8, 8'h34);
        step(1'b1, 8'h34);
        check_eq("k0_data", 32'(bus.out_data), 32'h34);
        check_eq("k0_shift", 32'(bus.shift_amount), 32'd0);
        for (int i = 2; i < FL; i++) step(1'b1, 8'h34);

        // False start: drop lock, then a data word resembling a sync.
        send_frame(8'h00, 8'h34);
        send_frame(8'h00, 8'h34);
        send_frame(rotl(SYNC, 1), 8'h00);
        step(1'b1, 8'h00);
        check_eq("false_start_unlocked", 32'(bus.locked), 32'd0);
        for (int i = 1; i < FL; i++) step(1'b1, 8'h00);

        // Random streams with random rotation, gaps and corrupted syncs.
        for (int r = 0; r < 12; r++) begin
            k = $urandom_range(0, 7);
            s = rotl(SYNC, k);
            for (int f = 0; f < 6; f++) begin
                for (int i = 0; i < FL; i++) begin
                    while ($urandom_range(0, 4) == 0) step(1'b0, 8'($urandom));
                    d = 8'($urandom);
                    if (i == 0) d = ($urandom_range(0, 5) == 0) ? d : s;
                    step(1'b1, d);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
